// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU share arbiter: ALU control codes, FSM states
// and the legality check for incoming op codes.
package alu_share_arbiter_pkg;

    // ALU control codes; must match the ALU control decoder.
    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_NOR = 4'b0011,
        OP_OR  = 4'b0100,
        OP_SLT = 4'b0101
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Legal codes are the contiguous range OP_ADD..OP_SLT.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_SLT);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is purely combinational; the priority
// pointer moves only when the owner of the grant is accepted (update).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // Pointer value p means requester p has priority on a tie.
    logic ptr_q;

    // A lone requester wins outright; on a tie the pointer decides.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After an accept, priority passes to the other requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (update) begin
            ptr_q <= ~grant[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the EX stage (requester 0) and the branch/address
// compare unit (requester 1): arbitrates, drives the ALU for ALU_LAT cycles,
// then returns the latched result with a one-cycle response pulse.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    input  logic [3:0]    req_op0,
    input  logic [3:0]    req_op1,
    input  logic [DW-1:0] req_a0,
    input  logic [DW-1:0] req_a1,
    input  logic [DW-1:0] req_b0,
    input  logic [DW-1:0] req_b1,
    output logic [1:0]    req_ready,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    output logic [1:0]    rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_zero,
    output logic          rsp_err
);

    localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

    state_e        state_q, state_d;
    logic [2:0]    lat_cnt_q;
    logic          owner_q;
    logic [1:0]    arb_req;
    logic [1:0]    grant;
    logic          accept;
    logic          win;
    logic [3:0]    sel_op;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;

    // Arbitration is only offered while idle; otherwise nobody is granted.
    assign arb_req   = (state_q == ST_IDLE) ? req_valid : 2'b00;
    assign req_ready = grant;
    assign win       = grant[1];

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (arb_req),
        .update (accept),
        .grant  (grant)
    );

    // Payload mux for the winning requester.
    always_comb begin
        sel_op = win ? req_op1 : req_op0;
        sel_a  = win ? req_a1  : req_a0;
        sel_b  = win ? req_b1  : req_b0;
    end

    // Next-state logic and accept decode.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    accept  = 1'b1;
                    state_d = is_legal_op(sel_op) ? ST_BUSY : ST_RESP;
                end
            end
            ST_BUSY: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response pulse goes to whichever requester owns the operation.
    always_comb begin
        rsp_valid = '0;
        if (state_q == ST_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    // Operand/result registers. The ALU output registers double as the
    // latched op/a/b: they load only for legal ops, so an illegal op leaves
    // the ALU inputs untouched while BUSY still sees stable latched values.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q   <= 1'b0;
            lat_cnt_q <= '0;
            alu_op    <= OP_ADD;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        owner_q   <= win;
                        lat_cnt_q <= '0;
                        if (is_legal_op(sel_op)) begin
                            alu_op <= sel_op;
                            alu_a  <= sel_a;
                            alu_b  <= sel_b;
                        end else begin
                            rsp_data <= '0;
                            rsp_zero <= 1'b0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    lat_cnt_q <= lat_cnt_q + 3'd1;
                    if (lat_cnt_q == LAT_LAST) begin
                        rsp_data <= alu_result;
                        rsp_zero <= alu_zero;
                        rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single datapath ALU, fed with 4-bit ALU control codes, between two requesters: requester 0 is the EX stage and requester 1 is the branch/address-compare unit.
- Arbitrates with a round-robin policy and drives the ALU operand and control lines.
- Waits the configured ALU latency, then latches the result and returns it to the winning requester with a one-cycle response pulse.
- Sits between the pipeline control logic and the ALU instance.

Parameters:
- DW, 32, operand and result width.
- ALU_LAT, 1, number of cycles from ALU inputs being stable to alu_result being valid (legal range 1..7).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i set: requester i presents an operation.
- req_op0, req_op1  in  4 each  ALU control code per requester.
- req_a0, req_a1  in  DW each  operand A per requester.
- req_b0, req_b1  in  DW each  operand B per requester.
- req_ready  out  2  one-hot grant/accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- alu_op  out  4  control code to the ALU.
- alu_a, alu_b  out  DW each  operands to the ALU.
- alu_result  in  DW  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  2  one-cycle pulse to the owning requester.
- rsp_data  out  DW  latched result.
- rsp_zero  out  1  latched zero flag.
- rsp_err  out  1  set together with rsp_valid when the op code was illegal.

Behaviour:
- Op codes (shared constants): ADD=0000, SUB=0001, AND=0010, NOR=0011, OR=0100, SLT=0101. Codes 0110..1111 are illegal.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready is asserted combinationally to exactly one valid requester, chosen by the rr pointer.
  - If only one requester is valid, it wins regardless of the pointer.
  - If none is valid, req_ready = 00.
  - On accept: op, a, b and the owner id are latched into registers; rr pointer <= ~owner.
  - Legal op: go to BUSY with lat_cnt = 0.
  - Illegal op: go straight to RESP with err=1 and data=0; the ALU is not driven, so alu_op holds its previous value.
- BUSY:
  - alu_op, alu_a and alu_b are driven from the latched registers and stay stable for the whole state.
  - lat_cnt increments each cycle.
  - When lat_cnt == ALU_LAT-1: latch alu_result and alu_zero, then go to RESP.
  - req_ready = 00.
- RESP:
  - rsp_valid[owner] = 1 for exactly one cycle; rsp_data, rsp_zero and rsp_err hold the latched values.
  - req_ready = 00. Next state: IDLE.
- rsp_data, rsp_zero and rsp_err hold their values after RESP until the next response.
- Latency:
  - Legal op accepted on cycle N: rsp_valid on cycle N+ALU_LAT+1.
  - Illegal op accepted on cycle N: rsp_valid on cycle N+1.
  - Maximum throughput is one op per ALU_LAT+2 cycles.
- Requesters must hold req_valid and their payload until accepted. A requester dropping valid before accept is legal; no grant occurs for it.
- Simultaneous requests alternate strictly: a requester that keeps requesting is never granted twice in a row while the other is waiting.
- The rr pointer changes only on accept.
- Reset values: state=IDLE, rr pointer=0 (requester 0 first), lat_cnt=0, req_ready=00, rsp_valid=00, rsp_data=0, rsp_zero=0, rsp_err=0, alu_op=0000 (ADD), alu_a=0, alu_b=0.
- Reset in BUSY or RESP aborts the operation; no rsp_valid is emitted.

Decomposition:
- Shared package contains:
  - the ALU op code constants (same values as the ALU control decoder);
  - the FSM state encoding;
  - an is_legal_op function.
- One sub-module, rr_arbiter2: a 2-way round-robin arbiter with an update enable. Pure grant logic plus the pointer register.

Test Plan:
- Reset, then req_valid=01, op0=ADD, a0=5, b0=7 (ALU_LAT=1) -> req_ready=01 in the accept cycle; alu_op=0000 for one cycle; rsp_valid=01 two cycles after accept with rsp_data=12 and rsp_zero=0.
- Both valid for 4 back-to-back ops each, with op0=SUB (a=3, b=3) and op1=SLT (a=1, b=2) -> grants in the order 0,1,0,1,…; responses: requester 0 gets data=0 with zero=1, requester 1 gets data=1 with zero=0.
- op1=4'b1001 -> rsp_valid=10 and rsp_err=1 on the cycle after accept, rsp_data=0; the ALU inputs are unchanged.
- ALU_LAT=3 with op0=NOR, a=0, b=0 -> alu_* held stable for 3 cycles; rsp_data=FFFFFFFF on accept+4.
- Assert reset in the second BUSY cycle -> no rsp_valid; all outputs at reset values; the next grant goes to requester 0.
- Requester 1 asserts valid during BUSY -> req_ready stays 00 until IDLE, then req_ready=10.
